fwd_hazard_unit: RTL and testbench

Parametrised operand-forwarding and hazard unit for the RV32IM pipeline. It resolves each decode-stage source operand against a configurable number of in-flight writeback sources, ordered youngest to oldest. It raises a stall when a matching source's data is not yet available (load-use), and keeps a register scoreboard for the multi-cycle MUL/DIV unit. It also counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit_pkg.sv | 16 +
 rtl/fwd_port_sel.sv | 45 ++++
 rtl/fwd_hazard_unit.sv | 83 ++++++++
 tb/tb_fwd_hazard_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the operand-forwarding / hazard unit.
// Register-file geometry is fixed by the RV32 architecture.
package fwd_hazard_unit_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // x0 is hard-wired to zero, so a zero address never takes part in forwarding.
  function automatic logic addr_hit(input logic en,
                                    input logic [REG_ADDR_W-1:0] a,
                                    input logic [REG_ADDR_W-1:0] b);
    return en && (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Combinational priority select and hazard detection for one source-operand port.
// Order: long-latency return > fwd source 0 (youngest) > ... > oldest > register file.
module fwd_port_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_ADDR_W-1:0]         addr,
  input  logic                          used,
  input  logic [XLEN-1:0]               rf_data,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic [NUM_FWD-1:0]            fwd_we,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic                          lat_done,
  input  logic [REG_ADDR_W-1:0]         lat_done_rd,
  input  logic [XLEN-1:0]               lat_done_data,
  input  logic [NUM_REGS-1:0]           sb_busy,
  output logic [XLEN-1:0]               data,
  output logic                          hazard
);

  logic pend;
  logic done_hit;

  always_comb begin
    data     = rf_data;
    pend     = 1'b0;
    done_hit = addr_hit(lat_done, lat_done_rd, addr);
    // Walk oldest to youngest so the youngest match overwrites older ones.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (addr_hit(fwd_we[i], fwd_addr[i*REG_ADDR_W +: REG_ADDR_W], addr)) begin
        data = fwd_data[i*XLEN +: XLEN];
        pend = !fwd_valid[i];
      end
    end
    if (done_hit) begin
      data = lat_done_data;
      pend = 1'b0;
    end
    hazard = used && (pend || (sb_busy[addr] && !done_hit));
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard unit: per-port select, MUL/DIV register
// scoreboard and a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_RS  = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RS*REG_ADDR_W-1:0]  rs_addr_i,
  input  logic [NUM_RS*XLEN-1:0]        rs_data_i,
  input  logic [NUM_RS-1:0]             rs_used_i,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data_i,
  input  logic [NUM_FWD-1:0]            fwd_we_i,
  input  logic [NUM_FWD-1:0]            fwd_valid_i,
  input  logic                          lat_issue_i,
  input  logic [REG_ADDR_W-1:0]         lat_issue_rd_i,
  input  logic                          lat_done_i,
  input  logic [REG_ADDR_W-1:0]         lat_done_rd_i,
  input  logic [XLEN-1:0]               lat_done_data_i,
  input  logic                          flush_i,
  output logic [NUM_RS*XLEN-1:0]        rs_data_o,
  output logic                          stall_o,
  output logic [NUM_REGS-1:0]           sb_busy_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  logic [NUM_REGS-1:0] sb_busy_q;
  logic [NUM_REGS-1:0] sb_busy_nxt;
  logic [NUM_RS-1:0]   port_haz;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic                issue_ok;

  for (genvar p = 0; p < NUM_RS; p++) begin : g_port
    fwd_port_sel #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD)
    ) u_sel (
      .addr          (rs_addr_i[p*REG_ADDR_W +: REG_ADDR_W]),
      .used          (rs_used_i[p]),
      .rf_data       (rs_data_i[p*XLEN +: XLEN]),
      .fwd_addr      (fwd_addr_i),
      .fwd_data      (fwd_data_i),
      .fwd_we        (fwd_we_i),
      .fwd_valid     (fwd_valid_i),
      .lat_done      (lat_done_i),
      .lat_done_rd   (lat_done_rd_i),
      .lat_done_data (lat_done_data_i),
      .sb_busy       (sb_busy_q),
      .data          (rs_data_o[p*XLEN +: XLEN]),
      .hazard        (port_haz[p])
    );
  end

  assign stall_o  = |port_haz;
  assign issue_ok = lat_issue_i && !flush_i && !stall_o && (lat_issue_rd_i != '0);

  // Clear before set so an issue and a return to the same rd leave it busy.
  always_comb begin
    sb_busy_nxt = sb_busy_q;
    if (lat_done_i) sb_busy_nxt[lat_done_rd_i] = 1'b0;
    if (issue_ok)   sb_busy_nxt[lat_issue_rd_i] = 1'b1;
    sb_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_busy_q <= sb_busy_nxt;
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign sb_busy_o   = sb_busy_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed cases followed by random
// traffic, compared against a behavioural model of the forwarding rules.
module tb_fwd_hazard_unit;

  localparam int XLEN    = 32;
  localparam int NUM_RS  = 2;
  localparam int NUM_FWD = 3;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_RS*5-1:0]    rs_addr_i;
  logic [NUM_RS*XLEN-1:0] rs_data_i;
  logic [NUM_RS-1:0]      rs_used_i;
  logic [NUM_FWD*5-1:0]   fwd_addr_i;
  logic [NUM_FWD*XLEN-1:0] fwd_data_i;
  logic [NUM_FWD-1:0]     fwd_we_i;
  logic [NUM_FWD-1:0]     fwd_valid_i;
  logic                   lat_issue_i;
  logic [4:0]             lat_issue_rd_i;
  logic                   lat_done_i;
  logic [4:0]             lat_done_rd_i;
  logic [XLEN-1:0]        lat_done_data_i;
  logic                   flush_i;
  logic [NUM_RS*XLEN-1:0] rs_data_o;
  logic                   stall_o;
  logic [31:0]            sb_busy_o;
  logic [CNT_W-1:0]       stall_cnt_o;

  fwd_hazard_unit #(
    .XLEN    (XLEN),
    .NUM_RS  (NUM_RS),
    .NUM_FWD (NUM_FWD),
    .CNT_W   (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs_addr_i       (rs_addr_i),
    .rs_data_i       (rs_data_i),
    .rs_used_i       (rs_used_i),
    .fwd_addr_i      (fwd_addr_i),
    .fwd_data_i      (fwd_data_i),
    .fwd_we_i        (fwd_we_i),
    .fwd_valid_i     (fwd_valid_i),
    .lat_issue_i     (lat_issue_i),
    .lat_issue_rd_i  (lat_issue_rd_i),
    .lat_done_i      (lat_done_i),
    .lat_done_rd_i   (lat_done_rd_i),
    .lat_done_data_i (lat_done_data_i),
    .flush_i         (flush_i),
    .rs_data_o       (rs_data_o),
    .stall_o         (stall_o),
    .sb_busy_o       (sb_busy_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  bit m_busy [32];
  int m_cnt;
  logic m_stall;
  logic [XLEN-1:0] m_data [NUM_RS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    m_cnt = 0;
  endtask

  // Youngest-first search: first matching producer wins.
  task automatic model_comb();
    m_stall = 1'b0;
    for (int p = 0; p < NUM_RS; p++) begin
      int  a;
      bit  found, pend, done_match;
      a          = int'(rs_addr_i[p*5 +: 5]);
      m_data[p]  = rs_data_i[p*XLEN +: XLEN];
      found      = 0;
      pend       = 0;
      done_match = lat_done_i && (int'(lat_done_rd_i) == a) && (a != 0);
      if (done_match) begin
        m_data[p] = lat_done_data_i;
        found = 1;
      end
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && a != 0 && fwd_we_i[i] && int'(fwd_addr_i[i*5 +: 5]) == a) begin
          m_data[p] = fwd_data_i[i*XLEN +: XLEN];
          pend  = !fwd_valid_i[i];
          found = 1;
        end
      end
      if (rs_used_i[p] && (pend || (m_busy[a] && !done_match))) m_stall = 1'b1;
    end
  endtask

  task automatic model_edge();
    bit issue_ok;
    issue_ok = lat_issue_i && !flush_i && !m_stall && lat_issue_rd_i != 0;
    if (lat_done_i) m_busy[lat_done_rd_i] = 1'b0;
    if (issue_ok)   m_busy[lat_issue_rd_i] = 1'b1;
    m_busy[0] = 1'b0;
    if (m_stall && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic idle_inputs();
    rs_addr_i = '0; rs_data_i = '0; rs_used_i = '0;
    fwd_addr_i = '0; fwd_data_i = '0; fwd_we_i = '0; fwd_valid_i = '1;
    lat_issue_i = 0; lat_issue_rd_i = '0; lat_done_i = 0; lat_done_rd_i = '0;
    lat_done_data_i = '0; flush_i = 0;
  endtask

  // Inputs are already driven; settle, then compare every output with the model.
  task automatic eval();
    #4;
    model_comb();
    for (int p = 0; p < NUM_RS; p++)
      check($sformatf("rs_data[%0d]", p), 64'(rs_data_o[p*XLEN +: XLEN]), 64'(m_data[p]));
    check("stall", 64'(stall_o), 64'(m_stall));
    check("sb_busy", 64'(sb_busy_o), 64'(model_busy_vec()));
    check("stall_cnt", 64'(stall_cnt_o), 64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_fwd(input int i, input logic [4:0] a, input logic [XLEN-1:0] d,
                         input logic we, input logic vld);
    fwd_addr_i[i*5 +: 5]       = a;
    fwd_data_i[i*XLEN +: XLEN] = d;
    fwd_we_i[i]                = we;
    fwd_valid_i[i]             = vld;
  endtask

  task automatic set_rs(input int p, input logic [4:0] a, input logic [XLEN-1:0] d, input logic u);
    rs_addr_i[p*5 +: 5]       = a;
    rs_data_i[p*XLEN +: XLEN] = d;
    rs_used_i[p]              = u;
  endtask

  int cnt_before;

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    set_rs(0, 5'd1, 32'hAAAA_0001, 1'b1);
    set_rs(1, 5'd2, 32'hBBBB_0002, 1'b1);
    #3;
    check("rst_sb_busy", 64'(sb_busy_o), 64'd0);
    check("rst_cnt", 64'(stall_cnt_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    eval();
    check("idle_pass0", 64'(rs_data_o[XLEN-1:0]), 64'h0000_0000_AAAA_0001);
    check("idle_nostall", 64'(stall_o), 64'd0);
    tick();

    // Youngest of two valid producers wins.
    idle_inputs();
    set_rs(0, 5'd5, 32'h5555_5555, 1'b1);
    set_fwd(0, 5'd5, 32'h11, 1'b1, 1'b1);
    set_fwd(2, 5'd5, 32'h33, 1'b1, 1'b1);
    eval();
    check("prio_src0", 64'(rs_data_o[XLEN-1:0]), 64'h11);
    check("prio_nostall", 64'(stall_o), 64'd0);
    tick();

    // Load-use on port 1, then unused port, then x0.
    idle_inputs();
    set_rs(1, 5'd7, 32'h7777_7777, 1'b1);
    set_fwd(0, 5'd7, 32'h77, 1'b1, 1'b0);
    eval();
    check("loaduse_stall", 64'(stall_o), 64'd1);
    tick();
    rs_used_i[1] = 1'b0;
    eval();
    check("unused_nostall", 64'(stall_o), 64'd0);
    tick();
    set_rs(1, 5'd0, 32'h0BAD_F00D, 1'b1);
    set_fwd(0, 5'd0, 32'h99, 1'b1, 1'b0);
    eval();
    check("x0_data", 64'(rs_data_o[2*XLEN-1:XLEN]), 64'h0BAD_F00D);
    check("x0_nostall", 64'(stall_o), 64'd0);
    tick();

    // DIV to x9, dependent read stalls 4 cycles, then result returns.
    idle_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd9;
    eval();
    tick();
    idle_inputs();
    set_rs(0, 5'd9, 32'h9999_9999, 1'b1);
    cnt_before = m_cnt;
    for (int c = 0; c < 4; c++) begin
      eval();
      check("div_stall", 64'(stall_o), 64'd1);
      tick();
    end
    check("div_cnt_plus4", 64'(stall_cnt_o), 64'(cnt_before + 4));
    lat_done_i = 1'b1; lat_done_rd_i = 5'd9; lat_done_data_i = 32'hDEAD;
    eval();
    check("div_fwd", 64'(rs_data_o[XLEN-1:0]), 64'hDEAD);
    check("div_release", 64'(stall_o), 64'd0);
    tick();
    idle_inputs();
    eval();
    check("div_busy_clr", 64'(sb_busy_o[9]), 64'd0);
    tick();

    // Issue and return to x3 together: issue wins. Flushed issue to x4 is dropped.
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd3;
    lat_done_i = 1'b1;  lat_done_rd_i = 5'd3;
    eval();
    tick();
    idle_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd4; flush_i = 1'b1;
    eval();
    check("set_wins", 64'(sb_busy_o[3]), 64'd1);
    tick();
    idle_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd0;
    eval();
    check("flush_drop", 64'(sb_busy_o[4]), 64'd0);
    tick();
    idle_inputs();
    lat_issue_i = 1'b1; lat_issue_rd_i = 5'd12;
    eval();
    check("x0_issue_ignored", 64'(sb_busy_o[0]), 64'd0);
    tick();

    // Asynchronous reset with busy bits outstanding.
    idle_inputs();
    eval();
    check("pre_rst_busy", 64'(sb_busy_o), 64'h0000_1008);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(sb_busy_o), 64'd0);
    check("async_rst_cnt", 64'(stall_cnt_o), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Drive the counter to all-ones minus one, then stall past saturation.
    idle_inputs();
    set_rs(0, 5'd6, 32'h6, 1'b1);
    set_fwd(1, 5'd6, 32'h60, 1'b1, 1'b0);
    for (int c = 0; c < 200 && m_cnt < CNT_MAX - 1; c++) begin
      eval();
      tick();
    end
    check("cnt_near_max", 64'(stall_cnt_o), 64'(CNT_MAX - 1));
    for (int c = 0; c < 3; c++) begin
      eval();
      tick();
    end
    check("cnt_saturated", 64'(stall_cnt_o), 64'(CNT_MAX));

    // Random traffic on a narrow register window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NUM_RS; p++)
        set_rs(p, 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < NUM_FWD; i++)
        set_fwd(i, 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) != 0));
      lat_issue_i     = ($urandom_range(0, 5) == 0);
      lat_issue_rd_i  = 5'($urandom_range(0, 7));
      flush_i         = ($urandom_range(0, 7) == 0);
      lat_done_i      = ($urandom_range(0, 2) == 0);
      lat_done_rd_i   = 5'($urandom_range(0, 7));
      lat_done_data_i = $urandom;
      if (n == 300) begin
        // Exercise the saturated counter after a second reset.
        rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
      end
      eval();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
